// File: rtl/sequenced_datapath_if.sv
// Word-addressed memory bus between the sequenced datapath (master) and its memory (slave).
// A transaction is held on the bus from mem_req until the cycle that carries mem_ack.
interface sequenced_datapath_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sequenced_datapath.sv
// Multi-cycle 16-bit-instruction datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// register file, {C,N,Z} flags and a single shared memory bus.
module sequenced_datapath #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      REGBITS  = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  sequenced_datapath_if.master bus,
  output logic [WIDTH-1:0]     pc_out,
  output logic [2:0]           psr_out,
  output logic                 halted
);
  localparam int unsigned NREGS = 2 ** REGBITS;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_SHI  = 4'h7;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_STOR = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_NOPD = 4'hD;
  localparam logic [3:0] OP_NOPE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;

  stateT              state, nextState;
  logic [15:0]        instr;
  logic [WIDTH-1:0]   pc, pcNext;
  logic [WIDTH-1:0]   regFile [NREGS];
  logic [WIDTH-1:0]   opA, opB, result;
  logic [2:0]         psr;

  logic [3:0]         op;
  logic [REGBITS-1:0] rdIdx, rsIdx;
  logic [WIDTH-1:0]   immS, immZ;
  logic [WIDTH:0]     addSum;
  logic [WIDTH-1:0]   aluResult;
  logic               aluCarry, setFlags;
  logic               memReqNext, memWeNext;
  logic [WIDTH-1:0]   memAddrNext, memWdataNext;

  assign op      = instr[15:12];
  assign rdIdx   = instr[8 +: REGBITS];
  assign rsIdx   = instr[0 +: REGBITS];
  assign immS    = {{(WIDTH - 8){instr[7]}}, instr[7:0]};
  assign immZ    = {{(WIDTH - 8){1'b0}}, instr[7:0]};
  assign pc_out  = pc;
  assign psr_out = psr;

  // Sequencing, ALU and next bus values; bus outputs are registered from the next state.
  always_comb begin
    nextState    = state;
    pcNext       = pc;
    aluResult    = opA;
    aluCarry     = psr[2];
    setFlags     = 1'b0;
    addSum       = {1'b0, opA} + {1'b0, (op == OP_ADDI) ? immS : opB};
    memReqNext   = 1'b0;
    memWeNext    = 1'b0;
    memAddrNext  = bus.mem_addr;
    memWdataNext = bus.mem_wdata;

    case (state)
      FETCH: begin
        if (bus.mem_req && bus.mem_ack) begin
          nextState = DECODE;
          pcNext    = pc + WIDTH'(1);
        end
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STOR: nextState = MEM;
          OP_HALT:          nextState = HALT;
          OP_NOPD, OP_NOPE: nextState = FETCH;
          default:          nextState = EXEC;
        endcase
      end
      EXEC: begin
        nextState = WB;
        case (op)
          OP_ADD, OP_ADDI: begin
            aluResult = addSum[WIDTH-1:0];
            aluCarry  = addSum[WIDTH];
            setFlags  = 1'b1;
          end
          OP_SUB, OP_CMP: begin
            aluResult = opA - opB;
            aluCarry  = (opA < opB);
            setFlags  = 1'b1;
            if (op == OP_CMP) nextState = FETCH;
          end
          OP_AND: begin aluResult = opA & opB; setFlags = 1'b1; end
          OP_OR:  begin aluResult = opA | opB; setFlags = 1'b1; end
          OP_XOR: begin aluResult = opA ^ opB; setFlags = 1'b1; end
          OP_MOVI: aluResult = immZ;
          OP_SHI: begin
            aluResult = instr[4] ? (opA >> instr[3:0]) : (opA << instr[3:0]);
            setFlags  = 1'b1;
          end
          OP_JAL: begin
            // pc already points past the JAL; opB holds rs as read before any write-back
            aluResult = pc;
            pcNext    = opB;
          end
          OP_BEQ: begin
            if (psr[0]) pcNext = pc + immS;
            nextState = FETCH;
          end
          default: nextState = FETCH;
        endcase
      end
      MEM: begin
        if (bus.mem_ack) nextState = (op == OP_LOAD) ? WB : FETCH;
      end
      WB:      nextState = FETCH;
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase

    case (nextState)
      FETCH: begin
        memReqNext  = 1'b1;
        memAddrNext = pcNext;
      end
      MEM: begin
        memReqNext = 1'b1;
        if (state == DECODE) begin
          memWeNext    = (op == OP_STOR);
          memAddrNext  = regFile[rsIdx];
          memWdataNext = regFile[rdIdx];
        end else begin
          memWeNext = bus.mem_we;
        end
      end
      default: ;
    endcase
  end

  // State, architectural registers and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= PC_RESET;
      instr         <= '0;
      opA           <= '0;
      opB           <= '0;
      result        <= '0;
      psr           <= '0;
      halted        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      for (int i = 0; i < int'(NREGS); i++) regFile[i] <= '0;
    end else begin
      state         <= nextState;
      pc            <= pcNext;
      halted        <= (nextState == HALT);
      bus.mem_req   <= memReqNext;
      bus.mem_we    <= memWeNext;
      bus.mem_addr  <= memAddrNext;
      bus.mem_wdata <= memWdataNext;
      case (state)
        FETCH:  if (bus.mem_req && bus.mem_ack) instr <= bus.mem_rdata[15:0];
        DECODE: begin
          opA <= regFile[rdIdx];
          opB <= regFile[rsIdx];
        end
        EXEC: begin
          result <= aluResult;
          if (setFlags) psr <= {aluCarry, aluResult[WIDTH-1], (aluResult == '0)};
        end
        MEM:     if (bus.mem_ack && op == OP_LOAD) result <= bus.mem_rdata;
        WB:      regFile[rdIdx] <= result;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sequenced_datapath.md
SEQUENCED_DATAPATH -- requirements
Module: sequenced_datapath

Interface
REQ-001 Parameter WIDTH, 16, datapath, register, address and PC width (>=16).
REQ-002 Parameter REGBITS, 4, register index width (<=4); register count = 2**REGBITS; fields use their low REGBITS bits.
REQ-003 Parameter PC_RESET, 16'h0000, PC value at reset.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 mem_req  out  1  memory transaction request.
REQ-007 mem_we  out  1  1=write, 0=read; valid while mem_req.
REQ-008 mem_addr  out  WIDTH  word address.
REQ-009 mem_wdata  out  WIDTH  store data.
REQ-010 mem_rdata  in  WIDTH  read data; valid when mem_ack.
REQ-011 mem_ack  in  1  completes the current transaction; ignored when mem_req=0.
REQ-012 pc_out  out  WIDTH  current PC.
REQ-013 psr_out  out  3  flags {C,N,Z}.
REQ-014 halted  out  1  high in HALT state.

Function
REQ-015 Instruction = mem_rdata[15:0]; op=[15:12], rd=[11:8], rs=[3:0], imm8=[7:0].
REQ-016 Ops: 0 ADD rd+=rs; 1 SUB rd-=rs; 2 AND; 3 OR; 4 XOR; 5 ADDI rd+=sext(imm8); 6 MOVI rd=zext(imm8); 7 SHI rd shifted by [3:0], [4]=0 left, 1 logical right; 8 LOAD rd=mem[rs]; 9 STOR mem[rs]=rd; A BEQ; B JAL; C CMP; F HALT; D,E NOP.
REQ-017 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; reset state FETCH.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, latch instruction, pc<=pc+1 (mod 2**WIDTH), go DECODE; otherwise stay.
REQ-019 DECODE: latch reg[rd] and reg[rs] into operand registers; LOAD/STOR->MEM, HALT->HALT, NOP->FETCH, others->EXEC.
REQ-020 EXEC: compute result; ALU ops/JAL->WB; BEQ/CMP->FETCH.
REQ-021 MEM: mem_req=1, mem_addr=reg[rs], mem_we=1 for STOR with mem_wdata=reg[rd]; on mem_ack LOAD->WB (data latched), STOR->FETCH.
REQ-022 WB: write result to rd; ->FETCH.
REQ-023 mem_addr, mem_we, mem_wdata held stable from request until the ack cycle inclusive; mem_req=0 in DECODE, EXEC, WB, HALT.
REQ-024 Latency with zero-wait memory (ack on the first request cycle): ALU/JAL 4 cycles, LOAD 4, STOR 3, BEQ/CMP 3, NOP 2.
REQ-025 BEQ: if Z=1, pc<=pc+sext(imm8) using the already-incremented PC; else PC unchanged; flags unchanged.
REQ-026 JAL: rd<=pc (return address = branch address+1); pc<=reg[rs]; when rd==rs, the jump uses the old reg[rs] value.
REQ-027 ADD/ADDI: C=carry out of bit WIDTH-1; SUB/CMP: C=1 iff rd<rs unsigned; all four set Z, N.
REQ-028 AND/OR/XOR/SHI: update Z, N; C unchanged; MOVI, LOAD, STOR, JAL, BEQ, NOP leave flags unchanged.
REQ-029 Flags update at the end of EXEC; Z=result==0; N=result[WIDTH-1].
REQ-030 Shift amount 0 gives an unchanged value; amount >= WIDTH is impossible (4-bit field, WIDTH>=16).
REQ-031 Arithmetic is modulo 2**WIDTH; PC wraps from all-ones to 0.
REQ-032 HALT: halted=1, no further transactions until reset.

Reset
REQ-033 On reset: pc=PC_RESET, all registers and psr=0, instruction register=0, state FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-034 Reset during an outstanding transaction drops mem_req at that edge; a same-cycle mem_ack has no effect.
REQ-035 Reset has priority over every state transition and register write.

Verification
REQ-036 MOVI r1,0x7F; MOVI r2,0x01; ADD r1,r2 -> r1=0x0080, Z=0, N=0, C=0; 12 cycles at zero wait.
REQ-037 r1=0xFFFF, ADDI r1,1 -> r1=0, Z=1, C=1; then BEQ +4 at address 0x10 -> pc=0x15.
REQ-038 STOR r3->[r4=0x0200] with ack delayed 3 cycles -> mem_req high for 4 cycles, addr/wdata stable; LOAD r5 from 0x0200 -> r5=r3.
REQ-039 JAL r15,r6 at 0x0020 with r6=0x0100 -> r15=0x0021, pc=0x0100; JAL r6,r6 -> jumps to old r6.
REQ-040 Reset asserted mid-FETCH with ack pending -> next cycle mem_req=0, pc=PC_RESET; then HALT -> halted=1, mem_req stays 0.
